// File: rtl/pe_result_deskew.sv
// pe_result_deskew: re-aligns the column-skewed results of the systolic
// array into whole row vectors and buffers them in a small FIFO that is
// drained over a valid/ready handshake. The array is never stalled, so a
// row that finds the FIFO full is dropped and the sticky overflow flag is set.
module pe_result_deskew #(
    parameter int ARRAY_SIZE             = 2,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     row_valid,
    input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results [ARRAY_SIZE-1:0],
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] out_data [ARRAY_SIZE-1:0],
    output logic [$clog2(FIFO_DEPTH):0]              fifo_level,
    output logic                                     overflow,
    input  logic                                     clear_overflow
);

    localparam int W     = ACCUMULATOR_DATA_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    // Row vector as it arrives at the FIFO write port, all columns aligned.
    logic signed [W-1:0] aligned [ARRAY_SIZE-1:0];
    logic                push;
    logic                pop;
    logic                accept;
    logic                drop;

    logic signed [W-1:0] mem [FIFO_DEPTH][ARRAY_SIZE];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    // Column c lags column 0 by c cycles, so it needs ARRAY_SIZE-1-c delay
    // stages to line up with the last column, which goes straight through.
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        localparam int STAGES = ARRAY_SIZE - 1 - c;
        if (STAGES == 0) begin : g_direct
            assign aligned[c] = results[c];
        end else begin : g_delay
            logic signed [W-1:0] stage [STAGES];

            // Free-running column delay line; it shifts every cycle so rows
            // issued back to back stay independent of each other.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < STAGES; s++) stage[s] <= '0;
                end else begin
                    stage[0] <= results[c];
                    for (int s = 1; s < STAGES; s++) stage[s] <= stage[s-1];
                end
            end

            assign aligned[c] = stage[STAGES-1];
        end
    end

    // The row marker travels alongside the slowest column so that it fires
    // exactly when the whole aligned row is present at the write port.
    if (ARRAY_SIZE == 1) begin : g_no_vpipe
        assign push = row_valid;
    end else begin : g_vpipe
        logic [ARRAY_SIZE-2:0] vpipe;

        // Valid shift register, one stage per skew stage of column 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vpipe <= '0;
            end else begin
                vpipe[0] <= row_valid;
                for (int s = 1; s < ARRAY_SIZE - 1; s++) vpipe[s] <= vpipe[s-1];
            end
        end

        assign push = vpipe[ARRAY_SIZE-2];
    end

    // A full FIFO can still take a row if its head leaves in the same cycle.
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = push && ((fifo_level < LVL_W'(FIFO_DEPTH)) || pop);
    assign drop      = push && !accept;

    // Row storage; only written on an accepted push so idle inputs never land here.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < ARRAY_SIZE; c++) mem[wr_ptr][c] <= aligned[c];
        end
    end

    // Head row goes straight out; forced to zero while the FIFO is empty.
    always_comb begin
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            out_data[c] = out_valid ? mem[rd_ptr][c] : '0;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_level <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky drop indicator; a fresh drop takes priority over a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
